// File: rtl/pattern_gen_pkg.sv
// Shared constants and types for the DVI stripe test-pattern source.
// Defaults describe the 800x600 bring-up mode.
package pattern_gen_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int     H_ACTIVE_DEF = 800;
    localparam int     V_ACTIVE_DEF = 600;
    localparam int     STRIPE_W_DEF = 64;
    localparam pixel_t COLOR_A_DEF  = 24'hFF33FF;
    localparam pixel_t COLOR_B_DEF  = 24'hFF3333;

    // Counter width for a 0..n-1 range; keeps degenerate n=1 at one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter that steps only when advance is high.
// nextX is exported so the colour register can look one pixel ahead.
module raster_counter
    import pattern_gen_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_DEF,
    parameter  int V_ACTIVE = V_ACTIVE_DEF,
    localparam int XW       = cntWidth(H_ACTIVE),
    localparam int YW       = cntWidth(V_ACTIVE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [XW-1:0] nextX,
    output logic          lineEnd,
    output logic          frameEnd
);

    assign lineEnd  = (x == XW'(H_ACTIVE - 1));
    assign frameEnd = lineEnd && (y == YW'(V_ACTIVE - 1));
    assign nextX    = lineEnd ? '0 : x + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= nextX;
            if (lineEnd)
                y <= frameEnd ? '0 : y + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_generator.sv
// Free-running vertical-stripe pixel source with a ready/valid output.
// Video always holds the colour of the pixel at the current raster position.
module pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int     H_ACTIVE = H_ACTIVE_DEF,
    parameter int     V_ACTIVE = V_ACTIVE_DEF,
    parameter int     STRIPE_W = STRIPE_W_DEF,
    parameter pixel_t COLOR_A  = COLOR_A_DEF,
    parameter pixel_t COLOR_B  = COLOR_B_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   VideoReady,
    output logic   VideoValid,
    output pixel_t Video
);

    localparam int XW = cntWidth(H_ACTIVE);
    localparam int YW = cntWidth(V_ACTIVE);
    localparam int SB = (STRIPE_W > 1) ? $clog2(STRIPE_W) : 0;

    logic          advance;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] nextX;
    logic          lineEnd;
    logic          frameEnd;
    logic          oddStripe;

    assign advance = VideoValid && VideoReady;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) uRaster (
        .clock    (clock),
        .reset    (reset),
        .advance  (advance),
        .x        (x),
        .y        (y),
        .nextX    (nextX),
        .lineEnd  (lineEnd),
        .frameEnd (frameEnd)
    );

    // Stripe parity is a single bit of x; stripes wider than the line never reach B.
    generate
        if (SB < XW) begin : gStripeBit
            assign oddStripe = nextX[SB];
        end else begin : gSingleStripe
            assign oddStripe = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            VideoValid <= 1'b0;
            Video      <= COLOR_A;
        end else begin
            VideoValid <= 1'b1;
            if (advance)
                Video <= oddStripe ? COLOR_B : COLOR_A;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Stripe pattern bench: default 800x600/64 instance plus a 20x3/8 instance for wrap cases.
module tb_pattern_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        rdyM, rdyS;
    logic        validM, validS;
    logic [23:0] videoM, videoS;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clock = ~clock;

    pattern_generator dutM (
        .clock      (clock),
        .reset      (reset),
        .VideoReady (rdyM),
        .VideoValid (validM),
        .Video      (videoM)
    );

    pattern_generator #(.H_ACTIVE(20), .V_ACTIVE(3), .STRIPE_W(8)) dutS (
        .clock      (clock),
        .reset      (reset),
        .VideoReady (rdyS),
        .VideoValid (validS),
        .Video      (videoS)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            if (nFail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] colourOf(input int x, input int s);
        return (((x / s) % 2) == 0) ? 24'hFF33FF : 24'hFF3333;
    endfunction

    // Reference: count of accepted transfers since reset; position follows by div/mod.
    int          cntM = 0, cntS = 0;
    bit          vExpM = 0, vExpS = 0;
    bit          heldM = 0, heldS = 0;
    logic [23:0] lastM, lastS;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cntM = 0; vExpM = 0; heldM = 0;
            cntS = 0; vExpS = 0; heldS = 0;
        end else begin
            heldM = vExpM && !rdyM;
            heldS = vExpS && !rdyS;
            if (vExpM && rdyM) cntM++;
            if (vExpS && rdyS) cntS++;
            vExpM = 1;
            vExpS = 1;
        end
    end

    always @(negedge clock) begin
        check("M.valid", validM, vExpM);
        check("M.video", videoM, colourOf(cntM % 800, 64));
        check("M.x", dutM.uRaster.x, cntM % 800);
        check("M.y", dutM.uRaster.y, (cntM / 800) % 600);
        if (heldM) check("M.hold", videoM, lastM);
        lastM = videoM;
        if (cntM == 64)  check("M.pix64",  videoM, 24'hFF3333);
        if (cntM == 127) check("M.pix127", videoM, 24'hFF3333);
        if (cntM == 128) check("M.pix128", videoM, 24'hFF33FF);
        if (cntM == 768) check("M.pix768", videoM, 24'hFF33FF);
        if (cntM == 800) check("M.line1",  videoM, 24'hFF33FF);

        check("S.valid", validS, vExpS);
        check("S.video", videoS, colourOf(cntS % 20, 8));
        check("S.x", dutS.uRaster.x, cntS % 20);
        check("S.y", dutS.uRaster.y, (cntS / 20) % 3);
        if (heldS) check("S.hold", videoS, lastS);
        lastS = videoS;
        if (cntS == 8)  check("S.pix8",  videoS, 24'hFF3333);
        if (cntS == 16) check("S.pix16", videoS, 24'hFF33FF);
        if (cntS == 19) check("S.pix19", videoS, 24'hFF33FF);
        if (cntS == 20) check("S.wrapX", videoS, 24'hFF33FF);
        if (cntS == 60) begin
            check("S.frameVideo", videoS, 24'hFF33FF);
            check("S.frameY", dutS.uRaster.y, 0);
        end
    end

    initial begin
        rdyS = 1'b0;
        forever begin
            @(negedge clock);
            rdyS = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        reset = 1'b0;
        rdyM  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.valid", validM, 0);
        check("rst.video", videoM, 24'hFF33FF);
        reset = 1'b1;
        @(posedge clock);
        #1 check("rel.valid", validM, 1);

        @(negedge clock);
        rdyM = 1'b1;
        for (int i = 0; i < 6000 && cntM < 4100; i++) @(negedge clock);
        check("M.reach_x100_y5", cntM, 4100);
        check("M.preRst.y", dutM.uRaster.y, 5);

        #2 reset = 1'b0;
        #1;
        check("midRst.valid", validM, 0);
        check("midRst.video", videoM, 24'hFF33FF);
        check("midRst.x", dutM.uRaster.x, 0);
        check("midRst.y", dutM.uRaster.y, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 30000 && cntM < 33 * 800; i++) @(negedge clock);
        check("M.reach33lines", cntM, 33 * 800);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            rdyM = ($urandom_range(0, 1) != 0);
        end
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
